// File: rtl/fc_layer_acc_if.sv
// fc_layer_acc_if: feature/weight/bias request and result stream signals of the FC layer engine
interface fc_layer_acc_if #(
  parameter int DATA_W   = 16,
  parameter int N_LANE   = 3,
  parameter int N_NEURON = 30,
  parameter int N_BATCH  = 16
);
  localparam int IDX_W = $clog2(N_NEURON);
  localparam int BC_W  = $clog2(N_BATCH + 1);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_LANE*DATA_W-1:0]   in_data;
  logic [IDX_W-1:0]           w_idx;
  logic [N_LANE*DATA_W-1:0]   w_data;
  logic [IDX_W-1:0]           b_idx;
  logic [DATA_W-1:0]          b_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [IDX_W-1:0]           out_idx;
  logic                       out_last;
  logic [BC_W-1:0]            batch_cnt;
  modport master (
    output in_valid, in_data, w_data, b_data, out_ready,
    input  in_ready, w_idx, b_idx, out_valid, out_data, out_idx, out_last, batch_cnt
  );
  modport slave (
    input  in_valid, in_data, w_data, b_data, out_ready,
    output in_ready, w_idx, b_idx, out_valid, out_data, out_idx, out_last, batch_cnt
  );
endinterface

// File: rtl/fc_layer_acc.sv
// fc_layer_acc: saturating multi-batch neuron accumulation, then biased/rescaled/ReLU result stream
module fc_layer_acc #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int N_LANE   = 3,
  parameter int N_NEURON = 30,
  parameter int N_BATCH  = 16,
  parameter int FRAC     = 10,
  parameter int RELU     = 1
) (
  input logic clk,
  input logic n_reset,
  input logic clear,
  fc_layer_acc_if.slave bus
);
  localparam int IDX_W = $clog2(N_NEURON);
  localparam int BC_W  = $clog2(N_BATCH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURON - 1);
  localparam logic [BC_W-1:0] NB = BC_W'(N_BATCH);
  localparam logic signed [ACC_W+1:0] A_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] A_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] D_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] D_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] k, j;
  logic [BC_W-1:0] batch_cnt;
  logic signed [DATA_W-1:0] in_reg [N_LANE];
  logic signed [ACC_W-1:0] acc [N_NEURON];
  logic signed [2*DATA_W-1:0] prod [N_LANE];
  logic signed [ACC_W+1:0] sum, tot;
  logic signed [ACC_W-1:0] acc_nxt, shifted;
  logic signed [ACC_W:0] biased;
  logic signed [DATA_W-1:0] res;
  logic accept, k_last, j_last, out_fire;
  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    assign prod[g] = in_reg[g] * $signed(bus.w_data[g*DATA_W +: DATA_W]);
  end
  // lane sum carries two guard bits so the saturation compare sees the true total
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_LANE; i++) sum = sum + (ACC_W+2)'(prod[i]);
    tot = (ACC_W+2)'(acc[k]) + sum;
    acc_nxt = tot > A_MAX ? A_MAX[ACC_W-1:0] : tot < A_MIN ? A_MIN[ACC_W-1:0] : tot[ACC_W-1:0];
  end
  assign shifted = acc[j] >>> FRAC;
  assign biased = (ACC_W+1)'(shifted) + (ACC_W+1)'($signed(bus.b_data));
  assign res = biased > D_MAX ? D_MAX[DATA_W-1:0] : biased < D_MIN ? D_MIN[DATA_W-1:0] : biased[DATA_W-1:0];
  assign accept = state == IDLE && bus.in_valid && !clear;
  assign k_last = k == LAST;
  assign j_last = j == LAST;
  assign out_fire = state == OUTPUT && bus.out_ready;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUTPUT;
  assign bus.w_idx = k;
  assign bus.b_idx = j;
  assign bus.out_idx = j;
  assign bus.out_last = bus.out_valid && j_last;
  assign bus.out_data = bus.out_valid ? ((RELU != 0 && res < 0) ? '0 : res) : '0;
  assign bus.batch_cnt = batch_cnt;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.in_valid ? ACCUM : IDLE;
      ACCUM:   state_nxt = !k_last ? ACCUM : (batch_cnt + 1'b1 == NB) ? OUTPUT : IDLE;
      OUTPUT:  state_nxt = out_fire && j_last ? IDLE : OUTPUT;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      k <= '0;
      j <= '0;
      batch_cnt <= '0;
      for (int i = 0; i < N_NEURON; i++) acc[i] <= '0;
      for (int i = 0; i < N_LANE; i++) in_reg[i] <= '0;
    end else if (clear) begin
      k <= '0;
      j <= '0;
      batch_cnt <= '0;
      for (int i = 0; i < N_NEURON; i++) acc[i] <= '0;
    end else begin
      if (accept)
        for (int i = 0; i < N_LANE; i++) in_reg[i] <= $signed(bus.in_data[i*DATA_W +: DATA_W]);
      if (state == ACCUM) begin
        acc[k] <= acc_nxt;
        k <= k_last ? '0 : k + 1'b1;
        if (k_last) batch_cnt <= batch_cnt + 1'b1;
      end
      if (out_fire) begin
        j <= j_last ? '0 : j + 1'b1;
        if (j_last) begin
          batch_cnt <= '0;
          for (int i = 0; i < N_NEURON; i++) acc[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fc_layer_acc.sv
// tb_fc_layer_acc: scoreboard bench driving a RELU=0 and a RELU=1 engine in lockstep
module tb_fc_layer_acc;
  localparam int NN = 4;
  localparam int NBT = 2;
  localparam int FRAC = 0;
  typedef struct {int idx; int data;} exp_t;
  logic clk = 0, n_reset = 0, clear = 0;
  logic in_valid = 0, out_ready = 1;
  logic [47:0] in_data = '0;
  logic signed [15:0] bias = 0;
  int wmode = 0;
  int checks = 0, errors = 0, cyc = 0;
  int pops0 = 0, first0 = 0, last0 = 0;
  exp_t q0[$], q1[$];
  longint macc [NN];
  int nb = 0;
  fc_layer_acc_if #(.DATA_W(16), .N_LANE(3), .N_NEURON(NN), .N_BATCH(NBT)) ia ();
  fc_layer_acc_if #(.DATA_W(16), .N_LANE(3), .N_NEURON(NN), .N_BATCH(NBT)) ib ();
  function automatic int wgt(int k, int mode);
    return mode == 0 ? k + 1 : mode == 1 ? -(k + 1) : mode == 2 ? 32767 : -32768;
  endfunction
  function automatic logic [47:0] wvec(logic [1:0] idx, int mode);
    logic [15:0] w;
    w = 16'(wgt(int'(idx), mode));
    return {w, w, w};
  endfunction
  assign ia.in_valid = in_valid;
  assign ib.in_valid = in_valid;
  assign ia.in_data = in_data;
  assign ib.in_data = in_data;
  assign ia.out_ready = out_ready;
  assign ib.out_ready = out_ready;
  assign ia.b_data = bias;
  assign ib.b_data = bias;
  assign ia.w_data = wvec(ia.w_idx, wmode);
  assign ib.w_data = wvec(ib.w_idx, wmode);
  fc_layer_acc #(.DATA_W(16), .ACC_W(32), .N_LANE(3), .N_NEURON(NN), .N_BATCH(NBT), .FRAC(FRAC), .RELU(0))
    dut0 (.clk(clk), .n_reset(n_reset), .clear(clear), .bus(ia));
  fc_layer_acc #(.DATA_W(16), .ACC_W(32), .N_LANE(3), .N_NEURON(NN), .N_BATCH(NBT), .FRAC(FRAC), .RELU(1))
    dut1 (.clk(clk), .n_reset(n_reset), .clear(clear), .bus(ib));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint clamp(longint v, longint lo, longint hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < NN; k++) macc[k] = 0;
    nb = 0;
  endtask
  task automatic accept(int a, int b, int c);
    int n = 0;
    in_data = {16'(c), 16'(b), 16'(a)};
    in_valid = 1;
    while (!ia.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic batch(int a, int b, int c);
    longint s, v;
    accept(a, b, c);
    for (int k = 0; k < NN; k++) begin
      s = (longint'(a) + longint'(b) + longint'(c)) * longint'(wgt(k, wmode));
      macc[k] = clamp(macc[k] + s, -64'sd2147483648, 64'sd2147483647);
    end
    nb++;
    if (nb == NBT) begin
      for (int k = 0; k < NN; k++) begin
        v = clamp((macc[k] >>> FRAC) + longint'(bias), -32768, 32767);
        q0.push_back('{k, int'(v)});
        q1.push_back('{k, v < 0 ? 0 : int'(v)});
      end
      model_reset();
    end
  endtask
  task automatic frame(int a, int b, int c);
    batch(a, b, c);
    batch(a, b, c);
  endtask
  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
    #1;
  endtask
  task automatic wait_idx(int idx);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ia.out_valid && int'(ia.out_idx) == idx) && n < 100);
    if (n >= 100) chk("idx_timeout", 0, 1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ia.out_valid && ia.out_ready) begin
      if (q0.size() == 0) chk("a_extra", 1, 0);
      else begin
        e = q0.pop_front();
        chk("a_data", $signed(ia.out_data), e.data);
        chk("a_idx", ia.out_idx, e.idx);
        chk("a_last", ia.out_last, e.idx == NN - 1);
        if (pops0 == 0) first0 = cyc;
        last0 = cyc;
        pops0++;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (ib.out_valid && ib.out_ready) begin
      if (q1.size() == 0) chk("b_extra", 1, 0);
      else begin
        e = q1.pop_front();
        chk("b_data", $signed(ib.out_data), e.data);
        chk("b_idx", ib.out_idx, e.idx);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", ia.in_ready, 1);
    chk("rst_out_valid", ia.out_valid, 0);
    chk("rst_out_last", ia.out_last, 0);
    chk("rst_out_idx", ia.out_idx, 0);
    chk("rst_w_idx", ia.w_idx, 0);
    chk("rst_batch_cnt", ia.batch_cnt, 0);
    chk("rst_out_data", ia.out_data, 0);
    n_reset = 1;
    @(posedge clk); #1;
    pops0 = 0;
    batch(1, 2, 3);
    chk("busy_in_ready", ia.in_ready, 0);
    batch(1, 2, 3);
    drain();
    chk("basic_pops", pops0, 4);
    chk("basic_consec", last0 - first0, 3);
    chk("basic_in_ready", ia.in_ready, 1);
    chk("basic_batch_cnt", ia.batch_cnt, 0);
    frame(1, 2, 3);
    wait_idx(1);
    out_ready = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_valid", ia.out_valid, 1);
      chk("hold_data", $signed(ia.out_data), 24);
      chk("hold_idx", ia.out_idx, 1);
    end
    out_ready = 1;
    drain();
    wmode = 1;
    bias = 5;
    frame(1, 2, 3);
    drain();
    wmode = 2;
    bias = 0;
    frame(32767, 32767, 32767);
    drain();
    wmode = 3;
    frame(32767, 32767, 32767);
    drain();
    wmode = 0;
    batch(1, 2, 3);
    accept(9, 9, 9);
    @(posedge clk); #1;
    clear = 1;
    @(posedge clk); #1;
    in_valid = 1;
    @(posedge clk); #1;
    clear = 0;
    in_valid = 0;
    model_reset();
    chk("clr_in_ready", ia.in_ready, 1);
    chk("clr_batch_cnt", ia.batch_cnt, 0);
    chk("clr_out_valid", ia.out_valid, 0);
    frame(1, 2, 3);
    drain();
    frame(1, 2, 3);
    wait_idx(2);
    out_ready = 0;
    #2 n_reset = 0;
    #1;
    chk("nrst_out_valid", ia.out_valid, 0);
    chk("nrst_out_idx", ia.out_idx, 0);
    chk("nrst_out_data", ia.out_data, 0);
    chk("nrst_out_last", ia.out_last, 0);
    chk("nrst_batch_cnt", ia.batch_cnt, 0);
    chk("nrst_b_out_valid", ib.out_valid, 0);
    q0.delete();
    q1.delete();
    model_reset();
    @(posedge clk); #1;
    n_reset = 1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("nrst_in_ready", ia.in_ready, 1);
    frame(1, 2, 3);
    drain();
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
